// File: rtl/seg7_driver.sv
// seg7_driver: serial driver for an 8-digit 7-segment display behind a
// 64-bit shift-register chain. Each refresh request latches eight hex
// nibbles, encodes them as active-low segment bytes and shifts the 64-bit
// frame out MSB first, two clk cycles per bit (clock low, then high).
module seg7_driver (
  input  logic        clk,
  input  logic        rst,
  input  logic        seg_clk,
  input  logic [31:0] data,
  output logic        SEG_CLK,
  output logic        SEG_SOUT,
  output logic        SEG_PEN,
  output logic        SEG_CLRN
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync2_q, prev_q, req_q, clrn_q;
  logic [6:0]  cnt_q, cnt_d;
  logic [6:0]  cnt_inc;
  logic [5:0]  bit_idx;
  logic [63:0] frame_q, frame_d;
  logic        sclk_q, sclk_d;
  logic        sout_q, sout_d;
  logic        pen_q, pen_d;
  logic        done_q, done_d;

  // Hex nibble to segment byte: dp off (1) above the inverted gfedcba pattern.
  function automatic logic [7:0] seg_byte(input logic [3:0] nib);
    logic [6:0] p;
    p = 7'h00;
    case (nib)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      4'hF: p = 7'h71;
      default: p = 7'h00;
    endcase
    return {1'b1, ~p};
  endfunction

  // Digit 7 lands in the top byte so it is shifted out first.
  function automatic logic [63:0] build_frame(input logic [31:0] d);
    logic [63:0] f;
    f = '0;
    for (int i = 0; i < 8; i++) begin
      f[8*i +: 8] = seg_byte(d[4*i +: 4]);
    end
    return f;
  endfunction

  // Synchronise seg_clk, register its rising edge as a one-cycle request, release clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      req_q   <= 1'b0;
      clrn_q  <= 1'b0;
    end else begin
      sync1_q <= seg_clk;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      req_q   <= sync2_q & ~prev_q;
      clrn_q  <= 1'b1;
    end
  end

  // Control state and registered chain outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sclk_q  <= 1'b0;
      sout_q  <= 1'b1;
      pen_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sclk_q  <= sclk_d;
      sout_q  <= sout_d;
      pen_q   <= pen_d;
      done_q  <= done_d;
    end
  end

  // Frame holding register; only read while shifting, so it needs no reset.
  always_ff @(posedge clk) begin
    frame_q <= frame_d;
  end

  // Next state: cnt counts half-bit cycles 0..127; odd counts raise SEG_CLK.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    sclk_d  = 1'b0;
    sout_d  = 1'b1;
    pen_d   = done_q;
    done_d  = done_q;
    cnt_inc = cnt_q + 7'd1;
    bit_idx = ~cnt_inc[6:1];
    case (state_q)
      IDLE: begin
        if (req_q) begin
          frame_d = build_frame(data);
          state_d = SHIFT;
          cnt_d   = '0;
          sout_d  = frame_d[63];
          pen_d   = 1'b0;
        end
      end
      SHIFT: begin
        pen_d = 1'b0;
        if (cnt_q == 7'd127) begin
          state_d = IDLE;
          done_d  = 1'b1;
          pen_d   = 1'b1;
        end else begin
          cnt_d  = cnt_inc;
          sclk_d = cnt_inc[0];
          sout_d = frame_q[bit_idx];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign SEG_CLK  = sclk_q;
  assign SEG_SOUT = sout_q;
  assign SEG_PEN  = pen_q;
  assign SEG_CLRN = clrn_q;

endmodule

// File: tb/tb_seg7_driver.sv
// Testbench for seg7_driver: a timeline model of the display protocol,
// compared against the DUT outputs every cycle, plus directed frames with
// hand-computed serial streams.
module tb_seg7_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seg_clk = 1'b0;
  logic [31:0] data = 32'h0;
  logic        SEG_CLK, SEG_SOUT, SEG_PEN, SEG_CLRN;

  int checks = 0;
  int failures = 0;

  // Model state: edges counted since reset release.
  int          edge_n = 0;
  int          req_at = -1000;
  int          s_edge = 0;
  bit          active = 1'b0;
  bit          done_m = 1'b0;
  bit          prev_s = 1'b0;
  logic [63:0] mframe = '0;

  // Serial capture: one bit per SEG_CLK rise.
  int          rises = 0;
  logic [63:0] cap = '0;

  logic [6:0] pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_driver dut (
    .clk      (clk),
    .rst      (rst),
    .seg_clk  (seg_clk),
    .data     (data),
    .SEG_CLK  (SEG_CLK),
    .SEG_SOUT (SEG_SOUT),
    .SEG_PEN  (SEG_PEN),
    .SEG_CLRN (SEG_CLRN)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model_frame(input logic [31:0] d);
    logic [63:0] f;
    logic [3:0]  n;
    f = '0;
    for (int i = 0; i < 8; i++) begin
      n = d[4*i +: 4];
      f[8*i +: 8] = {1'b1, ~pat[n]};
    end
    return f;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Timeline model: a seg_clk rise sampled at edge e gives a request cycle
  // after edge e+2; if idle then, the frame starts at edge e+3 and lasts 128 cycles.
  task automatic model_loop();
    bit was_busy;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        edge_n = 0;
        req_at = -1000;
        active = 1'b0;
        done_m = 1'b0;
        prev_s = 1'b0;
      end else begin
        edge_n++;
        was_busy = active && ((edge_n - 1 - s_edge) < 128);
        if (active && (edge_n - s_edge) >= 128) begin
          active = 1'b0;
          done_m = 1'b1;
        end
        if (edge_n == req_at + 1 && !was_busy) begin
          active = 1'b1;
          s_edge = edge_n;
          mframe = model_frame(data);
        end
        if (seg_clk && !prev_s) req_at = edge_n + 2;
        prev_s = seg_clk;
      end
    end
  endtask

  // Per-cycle comparison against the model, plus serial capture.
  task automatic compare_loop();
    int   t;
    logic [3:0] e;
    logic prev_clk;
    logic prev_sout;
    bit   prev_ok;
    prev_clk  = 1'b0;
    prev_sout = 1'b1;
    prev_ok   = 1'b0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (rst) begin
        e = 4'b0001;
        prev_ok = 1'b0;
      end else begin
        t = edge_n - s_edge;
        if (active && t < 128) e = {1'b1, 1'b0, t[0], mframe[63 - t/2]};
        else e = {edge_n >= 1, done_m, 1'b0, 1'b1};
        e[3] = (edge_n >= 1);
      end
      check("outputs{clrn,pen,clk,sout}", {60'd0, SEG_CLRN, SEG_PEN, SEG_CLK, SEG_SOUT}, {60'd0, e});
      if (!rst && prev_ok && SEG_CLK)
        check("sout_hold_while_clk_high", {63'd0, SEG_SOUT}, {63'd0, prev_sout});
      if (!rst && SEG_CLK && !prev_clk) begin
        rises++;
        cap = {cap[62:0], SEG_SOUT};
      end
      prev_clk  = rst ? 1'b0 : SEG_CLK;
      prev_sout = SEG_SOUT;
      prev_ok   = !rst;
    end
  endtask

  task automatic wait_rises(input int base, input int target);
    for (int i = 0; i < 400; i++) begin
      if (rises - base >= target) break;
      tick(1);
    end
  endtask

  task automatic run_frame(input logic [31:0] d, input logic [63:0] lit, input string nm);
    int base;
    data = d;
    base = rises;
    seg_clk = 1'b1;
    tick(6);
    seg_clk = 1'b0;
    wait_rises(base, 64);
    tick(3);
    check({nm, "_rises"}, 64'(rises - base), 64'd64);
    check({nm, "_stream"}, cap, lit);
    check({nm, "_pen_after"}, {63'd0, SEG_PEN}, 64'd1);
  endtask

  initial begin
    int base;
    int n;
    fork
      model_loop();
      compare_loop();
    join_none

    // Pin the model's encoder to hand-computed frames.
    check("model_zero", model_frame(32'h00000000), 64'hC0C0C0C0C0C0C0C0);
    check("model_hex", model_frame(32'h0123ABCD), 64'hC0F9A4B08883C6A1);

    // Reset state and release.
    tick(3);
    check("reset_outs", {60'd0, SEG_CLRN, SEG_PEN, SEG_CLK, SEG_SOUT}, 64'b0001);
    rst = 1'b0;
    check("clrn_before_edge", {63'd0, SEG_CLRN}, 64'd0);
    tick(1);
    check("clrn_after_release", {63'd0, SEG_CLRN}, 64'd1);
    tick(10);
    check("no_shift_without_request", 64'(rises), 64'd0);

    // All zeros with latency measurement.
    data = 32'h00000000;
    base = rises;
    seg_clk = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      n++;
      if (SEG_CLK) break;
    end
    check("latency_to_first_seg_clk", 64'(n), 64'd5);
    tick(2);
    seg_clk = 1'b0;
    wait_rises(base, 64);
    tick(3);
    check("zeros_rises", 64'(rises - base), 64'd64);
    check("zeros_stream", cap, 64'hC0C0C0C0C0C0C0C0);
    check("zeros_pen_after", {63'd0, SEG_PEN}, 64'd1);

    // Digit order and full hex encoding.
    run_frame(32'h0123ABCD, 64'hC0F9A4B08883C6A1, "hex");

    // Busy: data change and second request during a frame are ignored.
    data = 32'h12345678;
    base = rises;
    seg_clk = 1'b1;
    tick(6);
    seg_clk = 1'b0;
    tick(20);
    check("pen_low_while_busy", {63'd0, SEG_PEN}, 64'd0);
    data = 32'hFFFFFFFF;
    seg_clk = 1'b1;
    tick(6);
    seg_clk = 1'b0;
    wait_rises(base, 64);
    tick(3);
    check("busy_stream_old_data", cap, 64'hF9A4B0999282F880);
    tick(150);
    check("busy_no_second_frame", 64'(rises - base), 64'd64);
    run_frame(32'hFFFFFFFF, 64'h8E8E8E8E8E8E8E8E, "all_f");

    // Reset in the middle of a frame.
    data = 32'h00000000;
    base = rises;
    seg_clk = 1'b1;
    tick(6);
    seg_clk = 1'b0;
    wait_rises(base, 20);
    #3;
    rst = 1'b1;
    #1;
    check("midframe_reset_outs", {60'd0, SEG_CLRN, SEG_PEN, SEG_CLK, SEG_SOUT}, 64'b0001);
    tick(2);
    rst = 1'b0;
    base = rises;
    tick(20);
    check("no_shift_after_reset", 64'(rises - base), 64'd0);
    check("pen_low_after_reset", {63'd0, SEG_PEN}, 64'd0);
    run_frame(32'h0123ABCD, 64'hC0F9A4B08883C6A1, "after_reset");

    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
